mdu_unit: RTL

//  Multiply/divide unit for the E stage of the 5-stage MIPS pipeline. It consumes
//  rs/rt operands read from the GRF (after forwarding) and owns the HI/LO registers.
//  It returns HI/LO through MDU_RD, which travels to the W stage as GRF_WD for mfhi/mflo.

---
 rtl/mdu_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs MULT/DIV as a multi-cycle
// busy window and commits the precomputed result at the end of that window.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDU_op,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic        MDU_req,
  output logic        MDU_start,
  output logic        MDU_busy,
  output logic [31:0] MDU_RD,
  output logic [31:0] MDU_HI,
  output logic [31:0] MDU_LO
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    hi_q, lo_q, phi_q, plo_q;
  logic           pwr_q;

  logic           is_arith, is_div, is_signed;
  logic [63:0]    a_ext, b_ext, prod;
  logic           a_neg, b_neg;
  logic [31:0]    a_mag, b_mag, divisor, uq, ur, quo, rem;
  logic [31:0]    res_hi_d, res_lo_d;
  logic           res_wr_d;

  assign is_arith  = (MDU_op >= OP_MULT) && (MDU_op <= OP_DIVU);
  assign is_div    = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
  assign is_signed = (MDU_op == OP_MULT) || (MDU_op == OP_DIV);

  assign MDU_start = is_arith && !MDU_req && (state_q == S_IDLE);
  assign MDU_busy  = (state_q == S_RUN);
  assign MDU_HI    = hi_q;
  assign MDU_LO    = lo_q;

  always_comb begin
    MDU_RD = 32'd0;
    if (MDU_op == OP_MFHI)      MDU_RD = hi_q;
    else if (MDU_op == OP_MFLO) MDU_RD = lo_q;
  end

  // Divide on magnitudes so INT_MIN / -1 falls out as 0x80000000 rem 0 without overflow.
  always_comb begin
    a_ext   = is_signed ? {{32{MDU_A[31]}}, MDU_A} : {32'd0, MDU_A};
    b_ext   = is_signed ? {{32{MDU_B[31]}}, MDU_B} : {32'd0, MDU_B};
    prod    = a_ext * b_ext;
    a_neg   = is_signed && MDU_A[31];
    b_neg   = is_signed && MDU_B[31];
    a_mag   = a_neg ? -MDU_A : MDU_A;
    b_mag   = b_neg ? -MDU_B : MDU_B;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq      = a_mag / divisor;
    ur      = a_mag % divisor;
    quo     = (a_neg ^ b_neg) ? -uq : uq;
    rem     = a_neg ? -ur : ur;
    res_hi_d = is_div ? rem : prod[63:32];
    res_lo_d = is_div ? quo : prod[31:0];
    res_wr_d = !(is_div && (MDU_B == 32'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (MDU_start) begin
            state_q <= S_RUN;
            cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            phi_q   <= res_hi_d;
            plo_q   <= res_lo_d;
            pwr_q   <= res_wr_d;
          end else if (!MDU_req) begin
            if (MDU_op == OP_MTHI) hi_q <= MDU_A;
            if (MDU_op == OP_MTLO) lo_q <= MDU_A;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= S_IDLE;
            if (pwr_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
